// File: rtl/m_pool_relu_1_pkg.sv
// Shared layer constants and helpers for the pooling stages.
package m_pool_relu_1_pkg;

  // Pooled pixel count of a 2x2 stride-2 max-pool over a w x h map.
  function automatic int pool_count(input int w, input int h);
    return (w / 2) * (h / 2);
  endfunction

  // Layer-1 feature map geometry (signed Q4.12 pixels).
  localparam int L1_MAP_W   = 88;
  localparam int L1_MAP_H   = 88;
  localparam int L1_DATA_W  = 16;
  localparam int L1_NUM_OUT = pool_count(L1_MAP_W, L1_MAP_H);

endpackage

// File: rtl/m_pool_relu_1_pool_line_buf.sv
// Half-row line buffer: simple dual-port RAM, synchronous read, old data on
// read-during-write to the same address. No reset so it maps to LUT RAM.
module pool_line_buf #(
  parameter int DEPTH = 44,
  parameter int AW    = 6,
  parameter int W     = 16
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] r_rdata;

  // Write port and registered read port; NBA ordering gives old data on collision.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/m_pool_relu_1.sv
// Streaming ReLU + 2x2 stride-2 max-pool for the layer-1 feature map.
// Horizontal pairs are reduced in h_max, the even-row pair maxima are parked
// in a half-row line buffer, and the odd-row pass finishes each window.
module m_pool_relu_1
  import m_pool_relu_1_pkg::*;
#(
  parameter int MAP_W   = L1_MAP_W,
  parameter int MAP_H   = L1_MAP_H,
  parameter int DATA_W  = L1_DATA_W,
  parameter int NUM_OUT = pool_count(MAP_W, MAP_H)
) (
  input  logic              clk_in,
  input  logic              rst_n,    // active-high async reset
  input  logic              start,
  input  logic [DATA_W-1:0] map_in,
  input  logic              save_in,
  output logic [DATA_W-1:0] map_out,
  output logic              save,
  output logic              ready
);

  localparam int CW = $clog2(MAP_W);
  localparam int RW = $clog2(MAP_H);
  localparam int AW = CW - 1;
  localparam int OW = $clog2(NUM_OUT + 1);

  logic        [CW-1:0]     r_col;
  logic        [RW-1:0]     r_row;
  logic        [OW-1:0]     r_out_cnt;
  logic signed [DATA_W-1:0] r_h_max;
  logic signed [DATA_W-1:0] r_map_out;
  logic                     r_save;
  logic                     r_ready;

  logic                     w_accept;
  logic                     w_col_odd;
  logic                     w_row_odd;
  logic                     w_col_last;
  logic                     w_row_last;
  logic signed [DATA_W-1:0] w_relu;
  logic signed [DATA_W-1:0] w_p;
  logic signed [DATA_W-1:0] w_lb_rd;
  logic signed [DATA_W-1:0] w_pool;
  logic        [AW-1:0]     w_addr;

  assign w_accept   = start & save_in & r_ready;
  assign w_col_odd  = r_col[0];
  assign w_row_odd  = r_row[0];
  assign w_col_last = (r_col == CW'(MAP_W - 1));
  assign w_row_last = (r_row == RW'(MAP_H - 1));
  assign w_addr     = r_col[CW-1:1];

  // ReLU floor, then signed maxes on non-negative operands; no width growth.
  assign w_relu = map_in[DATA_W-1] ? '0 : map_in;
  assign w_p    = (r_h_max > w_relu) ? r_h_max : w_relu;
  assign w_pool = (w_lb_rd > w_p) ? w_lb_rd : w_p;

  // Read is issued on every accepted pixel: the even-column read of an odd row
  // prefetches the entry that the following odd column consumes. Writes only
  // happen on even rows, so the odd-row read always sees the previous row.
  pool_line_buf #(
    .DEPTH (MAP_W / 2),
    .AW    (AW),
    .W     (DATA_W)
  ) u_line_buf (
    .clk     (clk_in),
    .i_we    (w_accept & w_col_odd & ~w_row_odd),
    .i_waddr (w_addr),
    .i_wdata (w_p),
    .i_re    (w_accept),
    .i_raddr (w_addr),
    .o_rdata (w_lb_rd)
  );

  // Raster position and horizontal pair maximum.
  always_ff @(posedge clk_in or posedge rst_n) begin
    if (rst_n) begin
      r_col   <= '0;
      r_row   <= '0;
      r_h_max <= '0;
    end else if (!start) begin
      r_col   <= '0;
      r_row   <= '0;
      r_h_max <= '0;
    end else if (w_accept) begin
      if (!w_col_odd) r_h_max <= w_relu;
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Window completion: one-cycle save pulse, map_out held between pulses.
  always_ff @(posedge clk_in or posedge rst_n) begin
    if (rst_n) begin
      r_map_out <= '0;
      r_save    <= 1'b0;
    end else if (!start) begin
      r_map_out <= '0;
      r_save    <= 1'b0;
    end else begin
      r_save <= 1'b0;
      if (w_accept && w_col_odd && w_row_odd) begin
        r_map_out <= w_pool;
        r_save    <= 1'b1;
      end
    end
  end

  // Output count (counted as each pulse is launched) and registered ready.
  always_ff @(posedge clk_in or posedge rst_n) begin
    if (rst_n) begin
      r_out_cnt <= '0;
      r_ready   <= 1'b1;
    end else if (start) begin
      r_ready <= (r_out_cnt != OW'(NUM_OUT));
      if (w_accept && w_col_odd && w_row_odd && (r_out_cnt != OW'(NUM_OUT)))
        r_out_cnt <= r_out_cnt + 1'b1;
    end
  end

  assign map_out = r_map_out;
  assign save    = r_save;
  assign ready   = r_ready;

endmodule

// File: tb/tb_m_pool_relu_1.sv
// Directed bench for m_pool_relu_1: hand-valued first windows, start drop,
// full gapless / gapped frames, post-frame lockout and async mid-frame reset.
module tb_m_pool_relu_1;

  localparam int MW = 88;
  localparam int MH = 88;
  localparam int NP = MW * MH;

  logic        clk_in = 1'b0;
  logic        rst_n  = 1'b1;
  logic        start  = 1'b0;
  logic [15:0] map_in = '0;
  logic        save_in = 1'b0;
  logic [15:0] map_out;
  logic        save;
  logic        ready;

  int n_cmp   = 0;
  int n_bad   = 0;
  int n_saves = 0;

  m_pool_relu_1 dut (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .start   (start),
    .map_in  (map_in),
    .save_in (save_in),
    .map_out (map_out),
    .save    (save),
    .ready   (ready)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Pixel sources: 0 = directed first windows then hash, 1 = row*88+col, 2 = hash.
  function automatic logic signed [15:0] pix(input int mode, input int r, input int c);
    int h;
    h = r * 1237 + c * 7919 + r * c * 31 + 17;
    if (mode == 1) return 16'(r * MW + c);
    if (mode == 0 && r < 2 && c < 4) begin
      case (r * 4 + c)
        0: return 16'sd100;
        1: return 16'sd300;
        2: return 16'shFFFB;
        3: return 16'shF000;
        4: return 16'sd200;
        5: return 16'sd50;
        6: return 16'shFFFF;
        default: return 16'sh8000;
      endcase
    end
    return 16'(h);
  endfunction

  function automatic int relu(input logic signed [15:0] v);
    int x;
    x = v;
    return (x < 0) ? 0 : x;
  endfunction

  // Reference window maximum for the window whose bottom-right pixel is (r,c).
  function automatic logic [15:0] model(input int mode, input int r, input int c);
    int m;
    m = relu(pix(mode, r - 1, c - 1));
    if (relu(pix(mode, r - 1, c)) > m) m = relu(pix(mode, r - 1, c));
    if (relu(pix(mode, r, c - 1)) > m) m = relu(pix(mode, r, c - 1));
    if (relu(pix(mode, r, c)) > m) m = relu(pix(mode, r, c));
    return 16'(m);
  endfunction

  // Entered and left on a falling edge; checks save/map_out one cycle after acceptance.
  task automatic push(input logic [15:0] v, input bit es, input logic [15:0] ev, input bit gap);
    map_in  = v;
    save_in = 1'b1;
    @(negedge clk_in);
    if (save === 1'b1) n_saves++;
    chk("save", {15'd0, save}, {15'd0, es});
    if (es) chk("map_out", map_out, ev);
    if (gap) begin
      save_in = 1'b0;
      map_in  = 16'h7FFF;
      @(negedge clk_in);
      chk("gap_save", {15'd0, save}, 16'd0);
    end
  endtask

  task automatic run_pix(input int mode, input bit gap, input int k0, input int k1);
    for (int k = k0; k < k1; k++) begin
      int r, c;
      bit es;
      r  = k / MW;
      c  = k % MW;
      es = (r % 2 == 1) && (c % 2 == 1);
      push(pix(mode, r, c), es, es ? model(mode, r, c) : 16'd0, gap);
    end
  endtask

  task automatic pulse_reset();
    save_in = 1'b0;
    start   = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk_in);
    @(negedge clk_in);
    rst_n = 1'b0;
    start = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk_in);
    chk("rst_map_out", map_out, 16'd0);
    chk("rst_save", {15'd0, save}, 16'd0);
    chk("rst_ready", {15'd0, ready}, 16'd1);
    rst_n = 1'b0;
    start = 1'b1;
    @(negedge clk_in);

    // Directed windows: (100,300,200,50) -> 300 ; all negative -> 0
    push(16'sd100, 1'b0, 16'd0, 1'b0);
    push(16'sd300, 1'b0, 16'd0, 1'b0);
    push(16'shFFFB, 1'b0, 16'd0, 1'b0);
    push(16'shF000, 1'b0, 16'd0, 1'b0);
    run_pix(0, 1'b0, 4, MW);
    push(16'sd200, 1'b0, 16'd0, 1'b0);
    push(16'sd50, 1'b1, 16'd300, 1'b0);
    push(16'shFFFF, 1'b0, 16'd0, 1'b0);
    push(16'sh8000, 1'b1, 16'd0, 1'b0);
    run_pix(0, 1'b0, MW + 4, 2 * MW);

    // Drop start mid-row: outputs clear, next pixel is again (0,0)
    run_pix(0, 1'b0, 2 * MW, 2 * MW + 3);
    save_in = 1'b0;
    start   = 1'b0;
    @(negedge clk_in);
    chk("stop_save", {15'd0, save}, 16'd0);
    chk("stop_map_out", map_out, 16'd0);
    chk("stop_ready", {15'd0, ready}, 16'd1);
    start = 1'b1;
    run_pix(0, 1'b0, 0, 2 * MW);
    save_in = 1'b0;

    // Full gapless frame of row*88+col
    pulse_reset();
    n_saves = 0;
    run_pix(1, 1'b0, 0, NP);
    chk("last_map_out", map_out, 16'd7743);
    chk("ready_at_last", {15'd0, ready}, 16'd1);
    save_in = 1'b0;
    @(negedge clk_in);
    chk("ready_fall", {15'd0, ready}, 16'd0);
    chk("save_after", {15'd0, save}, 16'd0);
    chk("frame_saves", 16'(n_saves), 16'd1936);

    // Lockout: ten more pixels after the frame is done
    for (int i = 0; i < 10; i++) begin
      save_in = 1'b1;
      map_in  = 16'sd1234;
      @(negedge clk_in);
      chk("lock_save", {15'd0, save}, 16'd0);
      chk("lock_map_out", map_out, 16'd7743);
      chk("lock_ready", {15'd0, ready}, 16'd0);
    end

    // Gapped frame: same outputs, nothing during gaps
    pulse_reset();
    n_saves = 0;
    run_pix(1, 1'b1, 0, NP);
    chk("gap_ready", {15'd0, ready}, 16'd0);
    chk("gap_last_map_out", map_out, 16'd7743);
    chk("gap_frame_saves", 16'(n_saves), 16'd1936);

    // Async reset in the middle of row 37, no clock edge before the check
    pulse_reset();
    run_pix(2, 1'b0, 0, 37 * MW + 20);
    save_in = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
    chk("arst_map_out", map_out, 16'd0);
    chk("arst_save", {15'd0, save}, 16'd0);
    chk("arst_ready", {15'd0, ready}, 16'd1);
    @(negedge clk_in);
    @(negedge clk_in);
    rst_n = 1'b0;
    n_saves = 0;
    run_pix(2, 1'b0, 0, NP);
    save_in = 1'b0;
    @(negedge clk_in);
    chk("post_rst_saves", 16'(n_saves), 16'd1936);
    chk("post_rst_ready", {15'd0, ready}, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/m_pool_relu_1.md
Name: m_pool_relu_1

Overview:
- Streaming ReLU plus 2x2 stride-2 max-pool stage that sits directly downstream of the first convolution layer.
- Consumes the 88x88 signed Q4.12 feature map, presented one pixel per save pulse in raster order.
- Emits a 44x44 pooled map, one pixel per output pulse, to the next layer's input stream.
- Uses a half-row line buffer, so no full-frame storage is required.

Parameters:
- MAP_W, 88, input map width in pixels (must be even)
- MAP_H, 88, input map height in rows (must be even)
- DATA_W, 16, signed pixel width
- NUM_OUT, 1936, pooled pixels per frame, equal to (MAP_W/2)*(MAP_H/2)

Ports:
- clk_in  in  1  system clock; all logic is on its rising edge
- rst_n  in  1  reset, asynchronous and active-high (despite the name); one clock, clk_in
- start  in  1  frame-enable from the sequencer; low clears position state
- map_in  in  DATA_W  signed conv pixel
- save_in  in  1  map_in is valid this cycle (driven by the conv stage's save)
- map_out  out  DATA_W  signed pooled pixel, always >= 0
- save  out  1  map_out is valid this cycle
- ready  out  1  high while the frame is incomplete; low once NUM_OUT pixels have been emitted

Behaviour:
- Reset (rst_n=1, async):
  - map_out=0, save=0, ready=1.
  - col, row, out_cnt, h_max cleared.
  - Line buffer contents are don't-care, because every entry is written on an even row before it is read.
- start=0 (synchronous):
  - col, row, h_max cleared; save=0; map_out=0.
  - out_cnt and ready are held.
  - Deasserting start mid-frame discards the partial 2x2 window.
- ReLU: r = map_in[DATA_W-1] ? 0 : map_in. All compares are signed, but operands are non-negative after ReLU.
- Counters:
  - col and row advance only on cycles where start=1, save_in=1 and ready=1. Gaps in save_in are allowed and everything holds during them.
  - col wraps from MAP_W-1 to 0 and increments row.
  - row wraps from MAP_H-1 to 0.
- Per accepted pixel:
  - col even: h_max <= r.
  - col odd: p = max(h_max, r).
    - row even: linebuf[col>>1] <= p.
    - row odd: map_out <= max(linebuf[col>>1], p); save <= 1 on the next cycle.
  - Line buffer read and write share an address on odd columns. The read must return the value written on the previous even row, never same-cycle data.
- save is a single-cycle pulse per pooled pixel. It is low in every other cycle, and map_out holds its last value while save is low.
- Latency: save rises exactly 1 cycle after the accepted pixel at (odd row, odd col).
- out_cnt increments on each save pulse and saturates at NUM_OUT.
- ready <= (out_cnt != NUM_OUT), registered, so it falls 1 cycle after the NUM_OUT-th save.
- While ready=0, save_in is ignored: no counter movement and no further save pulses.
- A new frame requires a rst_n pulse.
- Width: no arithmetic growth; a max of DATA_W-bit values stays DATA_W.

Decomposition:
- Shared package: MAP_W, MAP_H, DATA_W, NUM_OUT for layer 1.
- Shared package: a function computing the pooled count from width and height, reused by later pool stages.
- Sub-module pool_line_buf: MAP_W/2 x DATA_W simple dual-port RAM with synchronous read and separate read/write addresses. Read-during-write to the same address returns old data. Maps to distributed RAM.

Test Plan:
- Positive window: rows 0-1, cols 0-1 = 100, 300, 200, 50 -> first save 1 cycle after pixel (1,1), map_out=300.
- All-negative window: -5, -4096, -1, -32768 -> map_out=0 (ReLU floor).
- Full frame with pixel value = row*88+col -> 1936 save pulses, each value = (2i+1)*88+(2j+1); ready falls 1 cycle after the last pulse; out_cnt=1936.
- save_in toggled 1-0-1 over a whole frame -> output sequence identical to the gapless run; no save pulses during gaps.
- Extra 10 save_in pulses after ready=0 -> no save, map_out unchanged, counters unchanged.
- rst_n asserted mid-row 37 -> outputs go 0/0/1 immediately with no clock needed; the next frame from (0,0) produces correct results.
